// File: rtl/bypass_chain_ctrl_if.sv
// Requester and scan-chain signal bundle for the bypass chain sequencer.
// The slave modport is the sequencer. The master modport is the requesters plus the chain.
interface bypass_chain_ctrl_if #(
    parameter int unsigned CHAIN_W = 24
);
    logic               wu_req_i;
    logic [CHAIN_W-1:0] wu_wdata_i;
    logic               wu_ack_o;
    logic               sw_req_i;
    logic [CHAIN_W-1:0] sw_wdata_i;
    logic               sw_ack_o;
    logic [CHAIN_W-1:0] rdata_o;
    logic               busy_o;
    logic               chain_data_o;
    logic               chain_en_o;
    logic               chain_apply_o;
    logic               chain_data_i;

    modport slave (
        input  wu_req_i, wu_wdata_i, sw_req_i, sw_wdata_i, chain_data_i,
        output wu_ack_o, sw_ack_o, rdata_o, busy_o,
               chain_data_o, chain_en_o, chain_apply_o
    );

    modport master (
        output wu_req_i, wu_wdata_i, sw_req_i, sw_wdata_i, chain_data_i,
        input  wu_ack_o, sw_ack_o, rdata_o, busy_o,
               chain_data_o, chain_en_o, chain_apply_o
    );
endinterface

// File: rtl/bypass_chain_ctrl.sv
// Serially loads a wake-up or software word into the power-management bypass chain.
// It captures the old chain contents on the way, then pulses apply and acks the owner.
module bypass_chain_ctrl #(
    parameter int unsigned CHAIN_W = 24
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    bypass_chain_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_APPLY,
        ST_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [CHAIN_W-1:0] sreg_q, sreg_d;
    logic [CHAIN_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_wu_q, owner_wu_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic               apply_q, apply_d;
    logic               data_q, data_d;
    logic               wu_ack_q, wu_ack_d;
    logic               sw_ack_q, sw_ack_d;
    logic [CHAIN_W-1:0] grant_word;

    // Wake-up unit has fixed priority over software.
    assign grant_word = bus.wu_req_i ? bus.wu_wdata_i : bus.sw_wdata_i;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        owner_wu_d = owner_wu_q;
        busy_d     = busy_q;
        en_d       = en_q;
        apply_d    = 1'b0;
        data_d     = 1'b0;
        wu_ack_d   = 1'b0;
        sw_ack_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wu_req_i || bus.sw_req_i) begin
                    sreg_d     = grant_word;
                    cnt_d      = '0;
                    owner_wu_d = bus.wu_req_i;
                    busy_d     = 1'b1;
                    en_d       = 1'b1;
                    data_d     = grant_word[CHAIN_W-1];
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // New word leaves MSB first while the old contents arrive from the chain tail.
                sreg_d = {sreg_q[CHAIN_W-2:0], bus.chain_data_i};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CHAIN_W - 1)) begin
                    en_d    = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    data_d = sreg_q[CHAIN_W-2];
                end
            end
            ST_GAP: begin
                apply_d = 1'b1;
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                rdata_d  = sreg_q;
                wu_ack_d = owner_wu_q;
                sw_ack_d = ~owner_wu_q;
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            owner_wu_q <= 1'b0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            apply_q    <= 1'b0;
            data_q     <= 1'b0;
            wu_ack_q   <= 1'b0;
            sw_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            owner_wu_q <= owner_wu_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            apply_q    <= apply_d;
            data_q     <= data_d;
            wu_ack_q   <= wu_ack_d;
            sw_ack_q   <= sw_ack_d;
        end
    end

    assign bus.wu_ack_o      = wu_ack_q;
    assign bus.sw_ack_o      = sw_ack_q;
    assign bus.rdata_o       = rdata_q;
    assign bus.busy_o        = busy_q;
    assign bus.chain_data_o  = data_q;
    assign bus.chain_en_o    = en_q;
    assign bus.chain_apply_o = apply_q;
endmodule

// File: tb/tb_bypass_chain_ctrl.sv
// Directed bench for bypass_chain_ctrl, with a two-stage bypass chain model on the serial side.
// Cycle k of a transfer is the k-th falling edge after the grant edge, so the ack appears in cycle 27.
module tb_bypass_chain_ctrl;
    localparam int unsigned W = 24;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bypass_chain_ctrl_if #(.CHAIN_W(W)) bus ();

    bypass_chain_ctrl #(.CHAIN_W(W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    // Chain model: stage1 shifts in at its LSB, stage2 is the live copy taken on apply.
    logic [W-1:0] stage1   = '0;
    logic [W-1:0] stage2   = '0;
    logic [W-1:0] load_val = '0;
    logic         load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req)
            stage1 <= load_val;
        else if (bus.chain_en_o)
            stage1 <= {stage1[W-2:0], bus.chain_data_o};
        if (bus.chain_apply_o)
            stage2 <= stage1;
    end
    assign bus.chain_data_i = stage1[W-1];

    int   n_chk      = 0;
    int   n_fail     = 0;
    int   run_len    = 0;
    int   acks_since = 0;
    logic prev_en    = 1'b0;
    logic prev_busy  = 1'b0;
    int   cyc, ens, apps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. The per-cycle protocol invariants are checked at each falling edge.
    task automatic tick();
        @(negedge clk);
        chk("en_apply_excl", 32'(bus.chain_en_o & bus.chain_apply_o), 32'd0);
        if (!bus.chain_en_o)
            chk("data_zero_outside_shift", 32'(bus.chain_data_o), 32'd0);
        if (bus.chain_apply_o)
            chk("apply_after_en_low", 32'(prev_en), 32'd0);
        if (bus.chain_en_o)
            run_len++;
        else if (run_len != 0) begin
            chk("en_run_len", 32'(run_len), 32'(W));
            run_len = 0;
        end
        if (bus.busy_o && !prev_busy)
            acks_since = 0;
        if (bus.wu_ack_o || bus.sw_ack_o) begin
            acks_since++;
            chk("one_ack_per_grant", 32'(acks_since), 32'd1);
            chk("acks_exclusive", 32'(bus.wu_ack_o & bus.sw_ack_o), 32'd0);
        end
        prev_en   = bus.chain_en_o;
        prev_busy = bus.busy_o;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Run until an ack is seen, counting cycles from 'start' plus the enable and apply cycles.
    task automatic xfer(input int start, output int c, output int e, output int a);
        c = start;
        e = 0;
        a = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            c++;
            if (bus.chain_en_o)
                e++;
            if (bus.chain_apply_o)
                a++;
            if (bus.wu_ack_o || bus.sw_ack_o)
                return;
        end
        chk("ack_timeout", 32'(c), 32'd27);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wu_req_i   = 1'b0;
        bus.sw_req_i   = 1'b0;
        bus.wu_wdata_i = '0;
        bus.sw_wdata_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy",   32'(bus.busy_o),        32'd0);
        chk("rst_en",     32'(bus.chain_en_o),    32'd0);
        chk("rst_apply",  32'(bus.chain_apply_o), 32'd0);
        chk("rst_data",   32'(bus.chain_data_o),  32'd0);
        chk("rst_wu_ack", 32'(bus.wu_ack_o),      32'd0);
        chk("rst_sw_ack", 32'(bus.sw_ack_o),      32'd0);
        chk("rst_rdata",  32'(bus.rdata_o),       32'd0);
        rstn = 1'b1;
        tick();
        tick();
        chk("idle_no_req_busy", 32'(bus.busy_o), 32'd0);
        load_val = 24'h0007FF;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;

        // Basic software transfer
        bus.sw_wdata_i = 24'hA55A3C;
        bus.sw_req_i   = 1'b1;
        xfer(0, cyc, ens, apps);
        chk("t1_latency", 32'(cyc),  32'd27);
        chk("t1_en_cycles", 32'(ens), 32'd24);
        chk("t1_apply_pulses", 32'(apps), 32'd1);
        chk("t1_stage2", 32'(stage2), 32'hA55A3C);
        chk("t1_rdata", 32'(bus.rdata_o), 32'h0007FF);
        chk("t1_sw_ack", 32'(bus.sw_ack_o), 32'd1);
        chk("t1_wu_ack", 32'(bus.wu_ack_o), 32'd0);
        chk("t1_busy_in_ack", 32'(bus.busy_o), 32'd1);
        after_edge();
        bus.sw_req_i = 1'b0;
        tick();
        chk("t1_busy_after", 32'(bus.busy_o), 32'd0);
        chk("t1_ack_pulse", 32'(bus.sw_ack_o), 32'd0);

        // Simultaneous requests: wake-up first, then software
        bus.wu_wdata_i = 24'h123456;
        bus.sw_wdata_i = 24'hFEDCBA;
        bus.wu_req_i   = 1'b1;
        bus.sw_req_i   = 1'b1;
        xfer(0, cyc, ens, apps);
        chk("t2_wu_latency", 32'(cyc), 32'd27);
        chk("t2_wu_ack", 32'(bus.wu_ack_o), 32'd1);
        chk("t2_wu_sw_ack", 32'(bus.sw_ack_o), 32'd0);
        chk("t2_wu_stage2", 32'(stage2), 32'h123456);
        chk("t2_wu_rdata", 32'(bus.rdata_o), 32'hA55A3C);
        after_edge();
        bus.wu_req_i = 1'b0;
        tick();
        chk("t2_gap_busy", 32'(bus.busy_o), 32'd0);
        xfer(0, cyc, ens, apps);
        chk("t2_sw_latency", 32'(cyc), 32'd27);
        chk("t2_sw_ack", 32'(bus.sw_ack_o), 32'd1);
        chk("t2_sw_wu_ack", 32'(bus.wu_ack_o), 32'd0);
        chk("t2_sw_stage2", 32'(stage2), 32'hFEDCBA);
        chk("t2_sw_rdata", 32'(bus.rdata_o), 32'h123456);
        after_edge();
        bus.sw_req_i = 1'b0;
        tick();

        // Request dropped and data changed mid-shift
        bus.sw_wdata_i = 24'h0F0F0F;
        bus.sw_req_i   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.sw_req_i   = 1'b0;
        bus.sw_wdata_i = 24'hFFFFFF;
        xfer(5, cyc, ens, apps);
        chk("t3_latency", 32'(cyc), 32'd27);
        chk("t3_sw_ack", 32'(bus.sw_ack_o), 32'd1);
        chk("t3_stage2", 32'(stage2), 32'h0F0F0F);
        chk("t3_rdata", 32'(bus.rdata_o), 32'hFEDCBA);
        tick();
        tick();

        // Asynchronous reset at shift cycle 10
        bus.sw_wdata_i = 24'h333333;
        bus.sw_req_i   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #2 rstn = 1'b0;
        #1;
        chk("t4_en",     32'(bus.chain_en_o),    32'd0);
        chk("t4_apply",  32'(bus.chain_apply_o), 32'd0);
        chk("t4_data",   32'(bus.chain_data_o),  32'd0);
        chk("t4_busy",   32'(bus.busy_o),        32'd0);
        chk("t4_sw_ack", 32'(bus.sw_ack_o),      32'd0);
        chk("t4_rdata",  32'(bus.rdata_o),       32'd0);
        bus.sw_req_i = 1'b0;
        run_len = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("t4_stage2_kept", 32'(stage2), 32'h0F0F0F);
        bus.sw_wdata_i = 24'hC3C3C3;
        bus.sw_req_i   = 1'b1;
        xfer(0, cyc, ens, apps);
        chk("t4_latency", 32'(cyc), 32'd27);
        chk("t4_en_cycles", 32'(ens), 32'd24);
        chk("t4_stage2", 32'(stage2), 32'hC3C3C3);
        chk("t4_rdata_partial", 32'(bus.rdata_o), 32'h1E1E66);
        after_edge();
        bus.sw_req_i = 1'b0;
        tick();

        // Back-to-back: request held high through the ack
        bus.sw_wdata_i = 24'hAAAAAA;
        bus.sw_req_i   = 1'b1;
        xfer(0, cyc, ens, apps);
        chk("t6_first_latency", 32'(cyc), 32'd27);
        chk("t6_first_rdata", 32'(bus.rdata_o), 32'hC3C3C3);
        after_edge();
        bus.sw_wdata_i = 24'h555555;
        tick();
        chk("t6_idle_busy", 32'(bus.busy_o), 32'd0);
        xfer(0, cyc, ens, apps);
        chk("t6_second_latency", 32'(cyc), 32'd27);
        chk("t6_second_ack", 32'(bus.sw_ack_o), 32'd1);
        chk("t6_stage2", 32'(stage2), 32'h555555);
        chk("t6_rdata", 32'(bus.rdata_o), 32'hAAAAAA);
        after_edge();
        bus.sw_req_i = 1'b0;
        tick();
        tick();
        chk("final_idle_busy", 32'(bus.busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
